// File: rtl/hcsr04_sequencer_pkg.sv
// Shared rangefinder definitions for the HC-SR04 sequencer.
//   state_t : FSM state encoding (3-bit, fixed values relied on by downstream debug)
//   *_DEF   : default timing constants for a 50 MHz Clk
package hcsr04_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_ECHO_HIGH = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int TRIG_CYCLES_DEF   = 500;      // 10 us
  localparam int PERIOD_CYCLES_DEF = 3000000;  // 60 ms trigger-to-trigger
  localparam int ECHO_TIMEOUT_DEF  = 1900000;  // 38 ms
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int CNT_W_DEF         = 22;

endpackage

// File: rtl/hcsr04_sequencer_sync_bit.sv
// Single-bit synchroniser: STAGES flops in series, async reset to 0.
//   i_clk : destination clock
//   i_rst : async active-high reset
//   i_d   : asynchronous input
//   o_q   : i_d delayed by STAGES i_clk edges
module hcsr04_sequencer_sync_bit
  import hcsr04_sequencer_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/hcsr04_sequencer.sv
// HC-SR04 trigger/echo sequencer. Fires a periodic trigger, turns the
// asynchronous echo into a Clk-synchronous Gate and bounds every phase with a
// timeout so Gate can never stick high.
//   Clk     : system clock, rising edge
//   Rst     : async active-high reset (release expected synchronous to Clk)
//   Enable  : run periodic measurements; only looked at in IDLE
//   Echo    : raw sensor echo, asynchronous
//   Trig    : sensor trigger pulse (TRIG_CYCLES long)
//   Gate    : high while a valid echo is in progress
//   Done    : 1-cycle strobe, echo ended normally
//   Timeout : 1-cycle strobe, echo missing or too long
//   Busy    : high outside IDLE
module hcsr04_sequencer
  import hcsr04_sequencer_pkg::*;
#(
  parameter int TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int ECHO_TIMEOUT  = ECHO_TIMEOUT_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Enable,
  input  logic Echo,
  output logic Trig,
  output logic Gate,
  output logic Done,
  output logic Timeout,
  output logic Busy
);

  localparam logic [CNT_W-1:0] L_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_pcnt, r_scnt;
  logic             w_echo_s, w_done, w_tout;
  logic             r_trig, r_gate, r_done, r_tout, r_busy;

  hcsr04_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (Clk),
    .i_rst (Rst),
    .i_d   (Echo),
    .o_q   (w_echo_s)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tout = 1'b0;
    case (r_state)
      // A stuck-high echo blocks new triggers until it clears.
      ST_IDLE:      if (Enable && !w_echo_s) w_next = ST_TRIG;
      ST_TRIG:      if (r_scnt == L_TRIG_LAST) w_next = ST_WAIT_ECHO;
      // Echo arriving on the timeout cycle still counts as an echo.
      ST_WAIT_ECHO: if (w_echo_s) w_next = ST_ECHO_HIGH;
                    else if (r_scnt == L_TOUT_LAST) begin
                      w_next = ST_HOLDOFF;
                      w_tout = 1'b1;
                    end
      // Echo falling on the timeout cycle is a normal completion.
      ST_ECHO_HIGH: if (!w_echo_s) begin
                      w_next = ST_HOLDOFF;
                      w_done = 1'b1;
                    end else if (r_scnt == L_TOUT_LAST) begin
                      w_next = ST_HOLDOFF;
                      w_tout = 1'b1;
                    end
      // >= rather than == so a saturated period counter still drains to IDLE.
      ST_HOLDOFF:   if (r_pcnt >= L_PER_LAST) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Period counter: measures from trigger rise; frozen in IDLE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                       r_pcnt <= '0;
    else if (w_next == ST_TRIG && r_state != ST_TRIG) r_pcnt <= '0;
    else if (r_state != ST_IDLE && r_pcnt != L_CNT_MAX) r_pcnt <= r_pcnt + L_ONE;
  end

  // State counter: cycles spent in the current state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                    r_scnt <= '0;
    else if (w_next != r_state) r_scnt <= '0;
    else if (r_scnt != L_CNT_MAX) r_scnt <= r_scnt + L_ONE;
  end

  // Outputs registered from the next state so they line up with r_state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_trig <= 1'b0;
      r_gate <= 1'b0;
      r_done <= 1'b0;
      r_tout <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_trig <= (w_next == ST_TRIG);
      r_gate <= (w_next == ST_ECHO_HIGH);
      r_done <= w_done;
      r_tout <= w_tout;
      r_busy <= (w_next != ST_IDLE);
    end
  end

  assign Trig    = r_trig;
  assign Gate    = r_gate;
  assign Done    = r_done;
  assign Timeout = r_tout;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_hcsr04_sequencer.sv
// Bench for hcsr04_sequencer with small timing parameters. The reference
// model tracks a measurement as timestamps (trigger rise, gate rise, end
// cycle) and derives every expected output arithmetically from them.
module tb_hcsr04_sequencer;

  localparam int TRIG = 5;
  localparam int PER  = 200;
  localparam int TOUT = 100;
  localparam int SYNC = 2;
  localparam int CW   = 22;

  logic Clk = 1'b0, Rst = 1'b1, Enable = 1'b0, Echo = 1'b0;
  logic Trig, Gate, Done, Timeout, Busy;

  hcsr04_sequencer #(
    .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .ECHO_TIMEOUT(TOUT),
    .SYNC_STAGES(SYNC), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Echo(Echo),
    .Trig(Trig), .Gate(Gate), .Done(Done), .Timeout(Timeout), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0, n_vec = 0, n_err = 0;

  // model: edge index of trigger rise / gate rise / measurement end (-1 = none)
  int m_start = -1, m_echo = -1, m_end = -1;
  bit m_end_done = 1'b0;
  bit h1 = 1'b0, h2 = 1'b0;   // Echo sampled at the last two edges

  // observed-waveform statistics
  bit p_trig = 1'b0, p_gate = 1'b0;
  int last_rise = -1000, rise_gap = 0, n_rise = 0, trig_run = 0, last_trig_len = 0;
  int gate_run = 0, last_gate_len = 0, n_grise = 0, n_done = 0, n_tout = 0;

  task automatic chk(input logic got, input logic exp, input string tag);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, exp);
    end
  endtask

  // Called right after posedge number cyc.
  task automatic model_edge();
    bit es;
    int k;
    k = cyc;
    if (Rst) begin
      m_start = -1; m_echo = -1; m_end = -1; h1 = 1'b0; h2 = 1'b0;
      return;
    end
    es = h2;  // synchronised echo seen by the decision at this edge
    if (m_start < 0) begin
      if (Enable && !es) begin
        m_start = k; m_echo = -1; m_end = -1;
      end
    end else if (m_end >= 0) begin
      if (k - m_start == PER) m_start = -1;
    end else if (m_echo < 0) begin
      if (k - 1 - m_start >= TRIG) begin
        if (es) m_echo = k;
        else if (k - 1 - m_start - TRIG == TOUT - 1) begin
          m_end = k; m_end_done = 1'b0;
        end
      end
    end else begin
      if (!es) begin
        m_end = k; m_end_done = 1'b1;
      end else if (k - 1 - m_echo == TOUT - 1) begin
        m_end = k; m_end_done = 1'b0;
      end
    end
    h2 = h1;
    h1 = Echo;
  endtask

  task automatic check();
    bit eb, et, eg, ed, eo;
    eb = (m_start >= 0);
    et = eb && (cyc - m_start < TRIG);
    eg = eb && (m_echo >= 0) && (m_end < 0);
    ed = eb && (m_end == cyc) && m_end_done;
    eo = eb && (m_end == cyc) && !m_end_done;
    chk(Trig, et, "trig");
    chk(Gate, eg, "gate");
    chk(Done, ed, "done");
    chk(Timeout, eo, "timeout");
    chk(Busy, eb, "busy");
    if (Trig && !p_trig) begin
      rise_gap = cyc - last_rise; last_rise = cyc; n_rise++; trig_run = 0;
    end
    if (Trig) trig_run++;
    if (!Trig && p_trig) last_trig_len = trig_run;
    if (Gate && !p_gate) begin gate_run = 0; n_grise++; end
    if (Gate) gate_run++;
    if (!Gate && p_gate) last_gate_len = gate_run;
    if (Done) n_done++;
    if (Timeout) n_tout++;
    p_trig = Trig;
    p_gate = Gate;
  endtask

  task automatic tick(input bit en, input bit ech);
    Enable = en;
    Echo   = ech;
    @(posedge Clk);
    cyc++;
    model_edge();
    @(negedge Clk);
    check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len;
    bit e, ech;

    // 1: reset with echo toggling, then release with Enable high
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, i[0]);
    Rst = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    chk_int(last_trig_len, TRIG, "trig_len");
    chk_int(n_rise, 1, "first_trig_rise");

    // 2: normal echo of random length starting 10 cycles after Trig falls
    len = int'($urandom_range(30, 50));
    n_done = 0; n_tout = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < len; i++) tick(1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      if (Trig) begin ok = 1'b1; break; end
    end
    chk(ok, 1'b1, "wait_second_trig");
    chk_int(rise_gap, PER + 1, "trig_spacing");
    chk_int(last_gate_len, len, "gate_len");
    chk_int(n_done, 1, "done_count");
    chk_int(n_tout, 0, "no_timeout");

    // 3: echo never arrives
    n_done = 0; n_tout = 0; n_grise = 0;
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b0);
    chk_int(n_tout, 1, "noecho_timeout");
    chk_int(n_done, 0, "noecho_no_done");
    chk_int(n_grise, 0, "noecho_no_gate");

    // 4: echo stuck high
    n_done = 0; n_tout = 0; n_rise = 0;
    for (int i = 0; i < 360; i++) tick(1'b1, 1'b1);
    chk_int(last_gate_len, TOUT, "stuck_gate_len");
    chk_int(n_tout, 1, "stuck_timeout");
    chk_int(n_done, 0, "stuck_no_done");
    chk_int(n_rise, 1, "stuck_no_retrigger");
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      if (Trig) begin ok = 1'b1; break; end
    end
    chk(ok, 1'b1, "trig_after_unstick");

    // 5: async reset while Gate is high
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      if (!Trig) break;
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      if (Gate) begin ok = 1'b1; break; end
    end
    chk(ok, 1'b1, "gate_before_reset");
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk(Gate, 1'b0, "async_gate");
    chk(Trig, 1'b0, "async_trig");
    chk(Busy, 1'b0, "async_busy");
    n_done = 0; n_tout = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    Rst = 1'b0;
    tick(1'b1, 1'b0);
    chk(Trig, 1'b1, "restart_trig");
    chk_int(n_done + n_tout, 0, "reset_no_strobe");

    // 6: drop Enable during ECHO_HIGH
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      if (!Trig) break;
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      if (Gate) begin ok = 1'b1; break; end
    end
    chk(ok, 1'b1, "gate_before_disable");
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (Done) begin ok = 1'b1; break; end
    end
    chk(ok, 1'b1, "done_after_disable");
    n_rise = 0;
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b0);
    chk_int(n_rise, 0, "disabled_no_trig");
    chk(Busy, 1'b0, "disabled_idle");
    tick(1'b1, 1'b0);
    chk(Trig, 1'b1, "reenable_trig");

    // 7: random echo pulses and occasional Enable changes
    e = 1'b1; ech = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) ech = ~ech;
      if ($urandom_range(0, 399) == 0) e = ~e;
      tick(e, ech);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
